// File: rtl/memory_bus_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter for a single memory port and its MAR.
// Fixed 4-phase access: IDLE -> ADDR (MAR load) -> WAIT (strobe, timeout) -> RESP (done pulse).
module memory_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                mba_clk,
  input  logic                mba_rst_n,
  // instruction fetch side
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  // load/store side
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_done,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_err,
  // MAR / memory side
  output logic                mar_wr_en_o,
  output logic [ADDR_W-1:0]   mar_in_o,
  output logic                mem_rd_o,
  output logic                mem_wr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_ready_i,
  output logic                busy_o
);

  localparam int BE_W = DATA_W / 8;
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [7:0]      TMO_MAX    = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;

  state_t              state_q;
  logic                own_ls_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic [SC_W-1:0]     starve_q;
  logic [7:0]          tmo_q;
  logic                if_gnt_q, ls_gnt_q, if_done_q, ls_done_q;
  logic                mar_wr_en_q, mem_rd_q, mem_wr_q;
  logic [DATA_W-1:0]   if_rdata_q, ls_rdata_q;
  logic                if_err_q, ls_err_q;

  logic                ls_win_d;
  logic [7:0]          tmo_d;
  logic [DATA_W-1:0]   rdata_d;

  // LS has priority unless IF has already been passed over STARVE_LIMIT times in a row.
  assign ls_win_d = ls_req && !(if_req && (starve_q == STARVE_MAX));
  assign tmo_d    = tmo_q + 8'd1;
  assign rdata_d  = (mem_ready_i && !we_q) ? mem_rdata_i : '0;

  always_ff @(posedge mba_clk or negedge mba_rst_n) begin
    if (!mba_rst_n) begin
      state_q     <= IDLE;
      own_ls_q    <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      starve_q    <= '0;
      tmo_q       <= '0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      mar_wr_en_q <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      ls_err_q    <= 1'b0;
    end else begin
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      mar_wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_req || ls_req) begin
            state_q     <= ADDR;
            own_ls_q    <= ls_win_d;
            we_q        <= ls_win_d && ls_we;
            addr_q      <= ls_win_d ? ls_addr : if_addr;
            wdata_q     <= ls_win_d ? ls_wdata : '0;
            be_q        <= (ls_win_d && ls_we) ? ls_be : '1;
            if_gnt_q    <= !ls_win_d;
            ls_gnt_q    <= ls_win_d;
            mar_wr_en_q <= 1'b1;
            starve_q    <= (ls_win_d && if_req) ? starve_q + SC_W'(1) : '0;
          end
        end
        ADDR: begin
          state_q  <= WAIT;
          mem_rd_q <= !we_q;
          mem_wr_q <= we_q;
        end
        WAIT: begin
          tmo_q <= tmo_d;
          // ready on the final timeout cycle still counts as a good transfer
          if (mem_ready_i || (tmo_d == TMO_MAX)) begin
            state_q  <= RESP;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            if (own_ls_q) begin
              ls_done_q  <= 1'b1;
              ls_err_q   <= !mem_ready_i;
              ls_rdata_q <= rdata_d;
            end else begin
              if_done_q  <= 1'b1;
              if_err_q   <= !mem_ready_i;
              if_rdata_q <= rdata_d;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
          tmo_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_gnt      = if_gnt_q;
  assign ls_gnt      = ls_gnt_q;
  assign if_done     = if_done_q;
  assign ls_done     = ls_done_q;
  assign if_rdata    = if_rdata_q;
  assign ls_rdata    = ls_rdata_q;
  assign if_err      = if_err_q;
  assign ls_err      = ls_err_q;
  assign mar_wr_en_o = mar_wr_en_q;
  assign mar_in_o    = addr_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;
  assign busy_o      = (state_q != IDLE);

endmodule
